// File: rtl/stage_id.sv
// rtl/stage_id.sv - RV32I decode stage: IF/ID register, register file, immediate generator, load-use hazard detect
// Optional macro ID_WB_BYPASS_EN: same-cycle write-back to decode operand bypass.
module stage_id #(
    parameter int          XLEN     = 32,
    parameter int          NREGS    = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data,
    output logic [XLEN-1:0] id_imm,
    output logic            load_use_stall
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rd1_arr, rd2_arr;

    // IF/ID next state: flush beats stall beats load; reset handled in the register.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = if_pc;
            inst_d  = NOP_INST;
        end else if (!stall) begin
            valid_d = 1'b1;
            pc_d    = if_pc;
            inst_d  = if_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NOP_INST;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // Register file writes ignore stall/flush; x0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    assign id_valid = valid_q;
    assign id_pc    = pc_q;
    assign id_inst  = inst_q;
    assign id_rs1   = inst_q[19:15];
    assign id_rs2   = inst_q[24:20];
    assign id_rd    = inst_q[11:7];

    assign rd1_arr = (id_rs1 == 5'd0) ? '0 : rf_q[id_rs1];
    assign rd2_arr = (id_rs2 == 5'd0) ? '0 : rf_q[id_rs2];

`ifdef ID_WB_BYPASS_EN
    assign id_rs1_data = (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs1)) ? wb_data : rd1_arr;
    assign id_rs2_data = (wb_we && (wb_rd != 5'd0) && (wb_rd == id_rs2)) ? wb_data : rd2_arr;
`else
    assign id_rs1_data = rd1_arr;
    assign id_rs2_data = rd2_arr;
`endif

    always_comb begin
        id_imm = '0;
        case (inst_q[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                id_imm = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};
            7'b0100011:
                id_imm = {{(XLEN-12){inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
            7'b1100011:
                id_imm = {{(XLEN-13){inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                          inst_q[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                id_imm = {{(XLEN-32){inst_q[31]}}, inst_q[31:12], 12'b0};
            7'b1101111:
                id_imm = {{(XLEN-21){inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                          inst_q[30:21], 1'b0};
            default:
                id_imm = '0;
        endcase
    end

    assign load_use_stall = valid_q && ex_mem_read && (ex_rd != 5'd0) &&
                            ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: doc/stage_id.md
Name: stage_id

Overview:
Instruction-decode stage, directly downstream of the fetch stage. It contains:
- the IF/ID pipeline register;
- the 32x32 integer register file;
- the RV32I immediate generator;
- load-use hazard detection.

It consumes the fetched PC and instruction, and produces register operands, the immediate and a stall request. The stall request goes back to the PC controller and the fetch stage.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, architectural register count; register x0 is hardwired to zero.
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- if_pc  input  32  PC of the fetched instruction
- if_inst  input  32  fetched instruction word
- stall  input  1  hold the IF/ID register (external OR of hazard sources)
- flush  input  1  branch taken; kill the instruction being latched
- wb_we  input  1  register-file write enable from write-back
- wb_rd  input  5  write-back destination register
- wb_data  input  32  write-back data
- ex_mem_read  input  1  instruction in EX is a load
- ex_rd  input  5  destination register of the instruction in EX
- id_valid  output  1  IF/ID register holds a real instruction
- id_pc  output  32  latched PC
- id_inst  output  32  latched instruction
- id_rs1  output  5  id_inst[19:15]
- id_rs2  output  5  id_inst[24:20]
- id_rd  output  5  id_inst[11:7]
- id_rs1_data  output  32  operand 1
- id_rs2_data  output  32  operand 2
- id_imm  output  32  sign-extended immediate
- load_use_stall  output  1  hazard request to the upstream stages

Behaviour:
- Reset (synchronous, active-high; takes effect at the next rising clk while reset is high):
  - id_valid=0, id_pc=0, id_inst=NOP_INST.
  - All 32 registers cleared to 0.
  - A reset during a stall or flush overrides both.
- IF/ID register, priority order at each rising edge is reset > flush > stall > load:
  - flush: id_valid=0, id_inst=NOP_INST, id_pc=if_pc.
  - stall: all IF/ID fields hold their values.
  - otherwise: load if_pc and if_inst, and set id_valid=1.
  - Latency is one cycle from if_* to id_*.
- Register file:
  - Two combinational read ports, addressed by id_rs1 and id_rs2.
  - One synchronous write port: writes at the rising edge when wb_we=1 and wb_rd!=0.
  - Writes to x0 are discarded; reads of x0 always return 0.
  - The register file is written regardless of stall and flush.
- Immediate generation, selected by opcode id_inst[6:0]; sign bit is always inst[31]:
  - I-type (0000011, 0010011, 1100111): inst[31:20].
  - S-type (0100011): {inst[31:25], inst[11:7]}.
  - B-type (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}.
  - J-type (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - Any other opcode: 0.
- load_use_stall (combinational) = id_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - It is not gated by flush; the upstream control gives flush precedence.
  - A flushed slot has id_valid=0, so it never raises a hazard.
- Operands are driven even when id_valid=0; downstream stages qualify them with id_valid.

Optional Feature:
Macro: ID_WB_BYPASS_EN.
- Defined: write-through bypass is active.
  - If wb_we=1, wb_rd!=0 and wb_rd==id_rs1, then id_rs1_data=wb_data in the same cycle. The same rule applies to id_rs2.
  - This gives a zero-cycle write-back to decode forward.
- Undefined: reads return the stored array value only.
  - A same-cycle write becomes visible the cycle after the write edge.
  - The pipeline must then cover that window with one extra stall cycle.

Test Plan:
1. Reset sequence: hold reset=1 for 2 cycles, then release -> id_valid=0, id_inst=32'h00000013, id_pc=0; reading x1..x31 returns 0.
2. Load then hold: if_pc=0x100, if_inst=0x00500093 (addi x1,x0,5) -> next cycle id_valid=1, id_pc=0x100, id_rd=1, id_imm=5. Assert stall=1 for 2 cycles while changing if_* -> id_* stay unchanged.
3. Flush wins over stall: stall=1 and flush=1 in the same cycle -> next cycle id_valid=0, id_inst=NOP_INST.
4. Write-back and x0:
   - wb_we=1, wb_rd=3, wb_data=0xDEADBEEF, then id_inst reads rs1=3 -> id_rs1_data=0xDEADBEEF.
   - wb_rd=0 with wb_data=0x1234 -> x0 still reads 0.
   - With ID_WB_BYPASS_EN defined, the same-cycle read returns 0xDEADBEEF.
5. Load-use hazard: id_inst=0x00208133 (add x2,x1,x2), ex_mem_read=1, ex_rd=1 -> load_use_stall=1. With ex_rd=0 or ex_mem_read=0 -> load_use_stall=0.
6. Immediates:
   - 0xFE000EE3 (beq, offset -4) -> id_imm=0xFFFFFFFC.
   - 0x123450B7 (lui) -> id_imm=0x12345000.
   - 0x0000006F (jal 0) -> id_imm=0.
